// File: rtl/csr_unit.sv
// Machine-mode CSR file with prioritised interrupt controller, trap/mret handling and 64-bit counters.
// Optional vectored trap targets are enabled by defining CSR_VECTORED_EN.
module csr_unit #(
   parameter int unsigned MXLEN   = 32,
   parameter int unsigned NUM_IRQ = 6,
   parameter int unsigned HARTID  = 0
) (
   input  logic               i_CLK,
   input  logic               i_RSTn,
   input  logic               i_CSR_EN,
   input  logic [2:0]         i_CSR_FUNCT3,
   input  logic [11:0]        i_CSR_ADDR,
   input  logic [MXLEN-1:0]   i_CSR_WDATA,
   output logic [MXLEN-1:0]   o_CSR_RDATA,
   output logic               o_CSR_ILLEGAL,
   input  logic [NUM_IRQ-1:0] i_IRQ,
   input  logic               i_TRAP_TAKE,
   input  logic               i_MRET,
   input  logic               i_RETIRE,
   input  logic [31:0]        i_PC,
   input  logic [31:0]        i_INSTR,
   output logic               o_IRQ,
   output logic [31:0]        o_TRAP_PC,
   output logic [31:0]        o_MEPC
);

   localparam logic [1:0] OpRw = 2'b01;
   localparam logic [1:0] OpRs = 2'b10;
   localparam logic [1:0] OpRc = 2'b11;

   logic               mstatus_mie_q, mstatus_mpie_q;
   logic [NUM_IRQ-1:0] mie_q, mip_q, pend;
   logic [31:0]        mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [63:0]        mcycle_q, minstret_q;
   logic [MXLEN-1:0]   rdata, wval;
   logic               implemented, read_only, wr_req, wr_en;
   logic [1:0]         op;
   logic [4:0]         sel;
   logic               unused_ok;

   assign unused_ok = ^{i_CSR_FUNCT3[2], i_PC[1:0]};
   assign op        = i_CSR_FUNCT3[1:0];

   always_comb begin
      implemented = 1'b1;
      read_only   = 1'b0;
      rdata       = '0;
      case (i_CSR_ADDR)
         12'hF11, 12'hF12, 12'hF13: read_only = 1'b1;
         12'hF14: begin read_only = 1'b1; rdata = MXLEN'(HARTID); end
         12'h300: rdata = {24'd0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
         12'h301: begin read_only = 1'b1; rdata = 32'h4000_0100; end
         12'h304: rdata = MXLEN'(mie_q);
         12'h305: rdata = mtvec_q;
         12'h340: rdata = mscratch_q;
         12'h341: rdata = mepc_q;
         12'h342: rdata = mcause_q;
         12'h343: rdata = mtval_q;
         12'h344: begin read_only = 1'b1; rdata = MXLEN'(mip_q); end
         12'hB00: rdata = mcycle_q[31:0];
         12'hB80: rdata = mcycle_q[63:32];
         12'hB02: rdata = minstret_q[31:0];
         12'hB82: rdata = minstret_q[63:32];
         default: implemented = 1'b0;
      endcase
   end

   // RS/RC with a zero operand is a pure read, so it may target read-only CSRs.
   assign wr_req = i_CSR_EN & ((op == OpRw) | (((op == OpRs) | (op == OpRc)) & (|i_CSR_WDATA)));
   assign o_CSR_ILLEGAL = ~implemented | (read_only & wr_req);
   assign wr_en  = wr_req & ~o_CSR_ILLEGAL;
   assign o_CSR_RDATA = rdata;

   always_comb begin
      wval = i_CSR_WDATA;
      case (op)
         OpRs:    wval = rdata | i_CSR_WDATA;
         OpRc:    wval = rdata & ~i_CSR_WDATA;
         default: wval = i_CSR_WDATA;
      endcase
   end

   assign pend = mip_q & mie_q;

   always_comb begin
      sel = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pend[i]) sel = 5'(i);
      end
   end

   assign o_IRQ  = mstatus_mie_q & (|pend);
   assign o_MEPC = mepc_q;

`ifdef CSR_VECTORED_EN
   assign o_TRAP_PC = (mtvec_q[1:0] == 2'b01) ?
                      ({mtvec_q[31:2], 2'b00} + {25'd0, 5'd16 + sel, 2'b00}) :
                      {mtvec_q[31:2], 2'b00};
`else
   assign o_TRAP_PC = mtvec_q;
`endif

   always_ff @(posedge i_CLK) begin
      if (!i_RSTn) begin
         mstatus_mie_q  <= 1'b1;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mip_q          <= '0;
         mtvec_q        <= '0;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mcycle_q       <= '0;
         minstret_q     <= '0;
      end else begin
         mip_q <= i_IRQ;

         if (i_TRAP_TAKE) begin
            mepc_q         <= {i_PC[31:2], 2'b00};
            mtval_q        <= i_INSTR;
            mcause_q       <= {1'b1, 26'd0, 5'd16 + sel};
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
         end else if (i_MRET) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
         end else if (wr_en) begin
            case (i_CSR_ADDR)
               12'h300: begin
                  mstatus_mie_q  <= wval[3];
                  mstatus_mpie_q <= wval[7];
               end
               12'h341: mepc_q   <= {wval[31:2], 2'b00};
               12'h342: mcause_q <= wval;
               12'h343: mtval_q  <= wval;
               default: ;
            endcase
         end

         if (wr_en) begin
            case (i_CSR_ADDR)
               12'h304: mie_q      <= wval[NUM_IRQ-1:0];
`ifdef CSR_VECTORED_EN
               12'h305: mtvec_q    <= {wval[31:2], wval[1] ? 2'b00 : wval[1:0]};
`else
               12'h305: mtvec_q    <= {wval[31:2], 2'b00};
`endif
               12'h340: mscratch_q <= wval;
               default: ;
            endcase
         end

         // A written counter holds its other half and skips this cycle's increment.
         if (wr_en && i_CSR_ADDR == 12'hB00)      mcycle_q[31:0]  <= wval;
         else if (wr_en && i_CSR_ADDR == 12'hB80) mcycle_q[63:32] <= wval;
         else                                     mcycle_q        <= mcycle_q + 64'd1;

         if (wr_en && i_CSR_ADDR == 12'hB02)      minstret_q[31:0]  <= wval;
         else if (wr_en && i_CSR_ADDR == 12'hB82) minstret_q[63:32] <= wval;
         else if (i_RETIRE)                       minstret_q        <= minstret_q + 64'd1;
      end
   end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit; follows CSR_VECTORED_EN when defined.
module tb_csr_unit;

   logic        clk = 1'b0;
   logic        rstn;
   logic        csr_en;
   logic [2:0]  funct3;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        illegal;
   logic [5:0]  irq;
   logic        trap_take, mret, retire;
   logic [31:0] pc, instr;
   logic        irq_out;
   logic [31:0] trap_pc, mepc;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   csr_unit #(.MXLEN(32), .NUM_IRQ(6), .HARTID(0)) dut (
      .i_CLK         (clk),
      .i_RSTn        (rstn),
      .i_CSR_EN      (csr_en),
      .i_CSR_FUNCT3  (funct3),
      .i_CSR_ADDR    (addr),
      .i_CSR_WDATA   (wdata),
      .o_CSR_RDATA   (rdata),
      .o_CSR_ILLEGAL (illegal),
      .i_IRQ         (irq),
      .i_TRAP_TAKE   (trap_take),
      .i_MRET        (mret),
      .i_RETIRE      (retire),
      .i_PC          (pc),
      .i_INSTR       (instr),
      .o_IRQ         (irq_out),
      .o_TRAP_PC     (trap_pc),
      .o_MEPC        (mepc)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // All tasks start and end at a falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic csr_wr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d);
      csr_en = 1'b1; funct3 = f3; addr = a; wdata = d;
      tick();
      csr_en = 1'b0; wdata = '0;
   endtask

   task automatic check_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csr_en = 1'b0; addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   initial begin
      rstn = 1'b0; csr_en = 1'b0; funct3 = 3'b001; addr = '0; wdata = '0;
      irq = '0; trap_take = 1'b0; mret = 1'b0; retire = 1'b0; pc = '0; instr = '0;
      tick(); tick();
      rstn = 1'b1;

      check_rd("rst_mstatus", 12'h300, 32'h0000_0008);
      check_rd("rst_misa", 12'h301, 32'h4000_0100);
      check_rd("rst_mhartid", 12'hF14, 32'h0);
      check_rd("rst_mie", 12'h304, 32'h0);
      check("rst_irq", {31'd0, irq_out}, 32'h0);
      check("rst_trap_pc", trap_pc, 32'h0);
      check("rst_mepc", mepc, 32'h0);

      csr_en = 1'b1; funct3 = 3'b010; addr = 12'h7C0; wdata = '0; #1;
      check("illegal_unimpl", {31'd0, illegal}, 32'h1);
      addr = 12'h301; #1;
      check("legal_ro_read", {31'd0, illegal}, 32'h0);
      funct3 = 3'b001; addr = 12'hF11; wdata = 32'h1; #1;
      check("illegal_ro_write", {31'd0, illegal}, 32'h1);
      csr_en = 1'b0;
      tick();
      check_rd("ro_unchanged", 12'hF11, 32'h0);

      csr_wr(3'b001, 12'h304, 32'h3F);
      check_rd("mie_rw", 12'h304, 32'h3F);
      csr_wr(3'b010, 12'h304, 32'h40);
      check_rd("mie_rs", 12'h304, 32'h3F);
      csr_wr(3'b011, 12'h304, 32'h01);
      check_rd("mie_rc", 12'h304, 32'h3E);
      csr_wr(3'b010, 12'h300, 32'h0);
      check_rd("mstatus_rs0", 12'h300, 32'h8);
      csr_wr(3'b001, 12'h300, 32'hFFFF_FFFF);
      check_rd("mstatus_mask", 12'h300, 32'h88);
      csr_wr(3'b001, 12'h300, 32'h8);
      csr_wr(3'b001, 12'h341, 32'h0000_1237);
      check_rd("mepc_align", 12'h341, 32'h1234);
      check("o_mepc", mepc, 32'h1234);
      csr_wr(3'b001, 12'h340, 32'hA5A5_5A5A);
      check_rd("mscratch", 12'h340, 32'hA5A5_5A5A);

      csr_wr(3'b001, 12'h304, 32'h3F);
      irq = 6'b010100; #1;
      check("irq_not_yet", {31'd0, irq_out}, 32'h0);
      tick();
      check("irq_asserted", {31'd0, irq_out}, 32'h1);
      check_rd("mip", 12'h344, 32'h14);

      pc = 32'h103; instr = 32'hDEAD_BEEF; trap_take = 1'b1;
      tick();
      trap_take = 1'b0;
      check_rd("trap_mepc", 12'h341, 32'h100);
      check_rd("trap_mcause", 12'h342, 32'h8000_0012);
      check_rd("trap_mtval", 12'h343, 32'hDEAD_BEEF);
      check_rd("trap_mstatus", 12'h300, 32'h80);
      check("trap_irq_low", {31'd0, irq_out}, 32'h0);

      mret = 1'b1;
      tick();
      mret = 1'b0;
      check_rd("mret_mstatus", 12'h300, 32'h88);
      check("mret_irq", {31'd0, irq_out}, 32'h1);

      trap_take = 1'b1; mret = 1'b1;
      tick();
      trap_take = 1'b0; mret = 1'b0;
      check_rd("trap_mret_mstatus", 12'h300, 32'h80);

      // Trap wins over a same-cycle mepc write.
      csr_wr(3'b001, 12'h300, 32'h8);
      csr_en = 1'b1; funct3 = 3'b001; addr = 12'h341; wdata = 32'h2000;
      pc = 32'h204; trap_take = 1'b1;
      tick();
      csr_en = 1'b0; trap_take = 1'b0;
      check_rd("trap_over_write", 12'h341, 32'h204);

      csr_wr(3'b001, 12'h300, 32'h8);
      irq = 6'b001000;
      csr_wr(3'b001, 12'h305, 32'h1001);
`ifdef CSR_VECTORED_EN
      check_rd("mtvec_vec", 12'h305, 32'h1001);
      check("trap_pc_vec", trap_pc, 32'h104C);
      csr_wr(3'b001, 12'h305, 32'h1003);
      check_rd("mtvec_mode1x", 12'h305, 32'h1000);
      check("trap_pc_mode1x", trap_pc, 32'h1000);
`else
      check_rd("mtvec_direct", 12'h305, 32'h1000);
      check("trap_pc_direct", trap_pc, 32'h1000);
`endif
      check("irq_pending3", {31'd0, irq_out}, 32'h1);
      csr_wr(3'b011, 12'h300, 32'h8);
      check("mie_clear_irq", {31'd0, irq_out}, 32'h0);
      irq = '0;

      csr_wr(3'b001, 12'hB00, 32'hFFFF_FFFF);
      tick();
      check_rd("mcycle_wrap_lo", 12'hB00, 32'h0);
      check_rd("mcycle_wrap_hi", 12'hB80, 32'h1);

      check_rd("minstret_idle", 12'hB02, 32'h0);
      retire = 1'b1;
      repeat (5) tick();
      retire = 1'b0;
      check_rd("minstret_5", 12'hB02, 32'h5);
      check_rd("minstreth_0", 12'hB82, 32'h0);

      rstn = 1'b0;
      csr_en = 1'b1; funct3 = 3'b001; addr = 12'h340; wdata = 32'h1234_5678;
      tick();
      csr_en = 1'b0; rstn = 1'b1;
      check_rd("reset_over_write", 12'h340, 32'h0);
      check_rd("reset_mstatus", 12'h300, 32'h8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/csr_unit.md
# csr_unit

Parametrised machine-mode CSR file with a multi-channel interrupt controller for the RV32I core. It sits beside the execute stage. It serves Zicsr read/write/set/clear accesses, latches and prioritises NUM_IRQ external interrupt lines, and performs trap entry and mret state updates. It also supplies the trap target PC, optionally in vectored mode, and maintains 64-bit cycle and retired-instruction counters.

## Interface
Parameters:
- MXLEN, 32: CSR width; only 32 supported.
- NUM_IRQ, 6: external interrupt channels, 1..16.
- HARTID, 0: value returned by mhartid.

Ports:
- i_CLK  in  1  clock.
- i_RSTn  in  1  reset, synchronous, active-low.
- i_CSR_EN  in  1  CSR instruction valid this cycle.
- i_CSR_FUNCT3  in  3  funct3; bits [1:0] give the op: 01 RW, 10 RS, 11 RC.
- i_CSR_ADDR  in  12  CSR address.
- i_CSR_WDATA  in  32  operand, already resolved from rs1 or zimm.
- o_CSR_RDATA  out  32  current value at i_CSR_ADDR, combinational.
- o_CSR_ILLEGAL  out  1  access to an unimplemented CSR, or a write to a read-only CSR.
- i_IRQ  in  NUM_IRQ  level interrupt requests.
- i_TRAP_TAKE  in  1  core commits interrupt entry this cycle.
- i_MRET  in  1  core commits mret this cycle.
- i_RETIRE  in  1  one instruction retired this cycle.
- i_PC  in  32  PC of the interrupted instruction.
- i_INSTR  in  32  interrupted instruction word.
- o_IRQ  out  1  interrupt request to the core.
- o_TRAP_PC  out  32  trap handler target.
- o_MEPC  out  32  mepc, used as the mret target.

## Operation
- Implemented CSRs: mvendorid, marchid, mimpid, mhartid (0xF11-0xF14, read-only, values 0, 0, 0, HARTID); mstatus 0x300; misa 0x301 (read-only, 0x40000100); mie 0x304; mtvec 0x305; mscratch 0x340; mepc 0x341; mcause 0x342; mtval 0x343; mip 0x344 (read-only); mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82.
- Write enable: i_CSR_EN & ~o_CSR_ILLEGAL, and not (RS/RC with i_CSR_WDATA==0).
- Write data per op:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
- Write masks:
  - mstatus: bits 3 (MIE) and 7 (MPIE) writable; all other bits read 0.
  - mie: bits [NUM_IRQ-1:0] writable; others 0.
  - mepc: bits [1:0] forced to 0.
- mip[k] is registered i_IRQ[k]: sampled every cycle, level-sensitive, not software-clearable.
- pend = mip & mie. sel = lowest set index of pend; index 0 has the highest priority.
- o_IRQ = mstatus.MIE & |pend.
- Trap entry (i_TRAP_TAKE):
  - mepc <= {i_PC[31:2], 2'b00}; mtval <= i_INSTR.
  - mcause <= {1'b1, 26'd0, 16+sel}. If pend==0, mcause <= {1, cause 16}.
  - MPIE <= MIE; MIE <= 0.
- mret (i_MRET): MIE <= MPIE; MPIE <= 1.
- Simultaneous i_TRAP_TAKE and i_MRET: trap entry wins and mret is ignored.
- Simultaneous trap or mret with a CSR write: the trap/mret update wins for mstatus, mepc, mcause and mtval. Writes to other CSRs proceed in the same cycle.
- Counters are 64-bit and wrap at 2^64-1 to 0.
  - mcycle increments every cycle.
  - minstret increments when i_RETIRE is high.
  - A software write to either half replaces that half, and that counter does not increment in that cycle.
  - The carry from the low half into the high half is suppressed when the low half is written.

## Timing
- Reads and o_CSR_ILLEGAL are combinational. Writes are visible on the cycle after the write.
- i_IRQ to o_IRQ: 1 cycle through mip, provided MIE and mie are set.
- A clear of MIE via CSR write deasserts o_IRQ on the next cycle.
- Trap entry: mcause, mepc and mstatus update on the clock edge where i_TRAP_TAKE is high. o_IRQ drops the following cycle because MIE=0.
- Reset values: mstatus = 0x00000008 (MIE=1). mie, mtvec, mscratch, mepc, mcause, mtval, mip and both counters are 0. Consequently:
  - o_IRQ = 0 and o_TRAP_PC = 0 out of reset.
  - o_MEPC = 0 and o_CSR_RDATA reflects the reset values.
- Reset asserted mid-operation overrides any simultaneous write, trap or mret.

## Configuration
- CSR_VECTORED_EN defined:
  - mtvec[1:0] is writable with modes 00 and 01; values 1x are stored as 00.
  - In mode 01, o_TRAP_PC = {mtvec[31:2], 2'b00} + 4*(16+sel).
  - In mode 00, o_TRAP_PC is the base.
- CSR_VECTORED_EN undefined: mtvec[1:0] is hardwired to 00 and o_TRAP_PC = {mtvec[31:2], 2'b00} always.

## Test plan
- Reset, then read 0x300, 0x301, 0xF14 -> 0x00000008, 0x40000100, HARTID. Read 0x7C0 -> o_CSR_ILLEGAL=1.
- RW mie=0x3F, RS mie 0x40, RC mie 0x01 -> reads 0x3F, 0x3F, 0x3E. RS of 0x300 with wdata 0 leaves mstatus unchanged.
- mie=0x3F; assert i_IRQ=6'b010100 -> o_IRQ=1 one cycle later. i_TRAP_TAKE with i_PC=0x103 -> mepc=0x100, mcause=0x80000012, mstatus=0x80, o_IRQ=0.
- i_MRET after that trap -> mstatus=0x88. Same-cycle i_TRAP_TAKE and i_MRET -> mstatus=0x80.
- mtvec=0x1001 with CSR_VECTORED_EN, irq 3 pending -> o_TRAP_PC=0x104C. Without the macro -> mtvec reads 0x1000 and o_TRAP_PC=0x1000.
- mcycle=0xFFFFFFFF written, then idle 1 cycle -> mcycle=0, mcycleh=1. i_RETIRE held 5 cycles -> minstret=5.
